// File: rtl/sc_statemachine_shifter.sv
// Control FSM for the 8-bit shift register: clears it, loads the switch
// pattern, then sweeps the pattern left and right at a prescaled pace.
// Outputs are registered and always equal the decode of the state register.
module sc_statemachine_shifter #(
  parameter int DATAWIDTH      = 8,
  parameter int PRESCALE_COUNT = 4,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic       SC_STATEMACHINE_CLOCK_50,
  input  logic       SC_STATEMACHINE_RESET_InLow,
  input  logic       SC_STATEMACHINE_start_InLow,
  input  logic       SC_STATEMACHINE_stop_InLow,
  input  logic       SC_STATEMACHINE_repeat_In,
  output logic       SC_STATEMACHINE_clear_OutLow,
  output logic       SC_STATEMACHINE_load_OutLow,
  output logic [1:0] SC_STATEMACHINE_shiftselection_Out,
  output logic       SC_STATEMACHINE_busy_Out,
  output logic       SC_STATEMACHINE_done_Out
);

  localparam int STEP_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [STEP_W-1:0]         STEP_LAST  = STEP_W'(DATAWIDTH - 2);
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_LAST = PRESCALE_WIDTH'(PRESCALE_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_WAITL,
    S_SHL,
    S_WAITR,
    S_SHR,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       clear_n;
    logic       load_n;
    logic [1:0] sel;
    logic       busy;
    logic       done;
  } out_t;

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic                      start_q, start_d;
  out_t                      out_q, out_d;
  logic                      start_fall;

  // Moore output decode; registered from the next state so the output flops
  // always mirror the state register.
  function automatic out_t decode(input state_t s);
    out_t o;
    o = '{clear_n: 1'b1, load_n: 1'b1, sel: 2'b00, busy: 1'b1, done: 1'b0};
    unique case (s)
      S_IDLE:  o.busy    = 1'b0;
      S_CLR:   o.clear_n = 1'b0;
      S_LOAD:  o.load_n  = 1'b0;
      S_SHL:   o.sel     = 2'b01;
      S_SHR:   o.sel     = 2'b10;
      S_DONE:  o.done    = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  assign start_fall = start_q & ~SC_STATEMACHINE_start_InLow;

  // Next-state, prescaler and step-counter logic; stop overrides everything
  // except reset, and start is only honoured from IDLE with stop released.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    step_d  = step_q;
    start_d = SC_STATEMACHINE_start_InLow;
    if ((state_q != S_IDLE) && !SC_STATEMACHINE_stop_InLow) begin
      state_d = S_IDLE;
      presc_d = '0;
      step_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_fall && SC_STATEMACHINE_stop_InLow) state_d = S_CLR;
        end
        S_CLR: state_d = S_LOAD;
        S_LOAD: begin
          state_d = S_WAITL;
          step_d  = '0;
          presc_d = '0;
        end
        S_WAITL, S_WAITR: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            state_d = (state_q == S_WAITL) ? S_SHL : S_SHR;
          end else begin
            presc_d = presc_q + PRESCALE_WIDTH'(1);
          end
        end
        S_SHL: begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            state_d = S_WAITR;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = S_WAITL;
          end
        end
        S_SHR: begin
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            state_d = SC_STATEMACHINE_repeat_In ? S_WAITL : S_DONE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = S_WAITR;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    out_d = decode(state_d);
  end

  // State, counters, start history and output registers with synchronous
  // active-low reset back to IDLE.
  always_ff @(posedge SC_STATEMACHINE_CLOCK_50) begin
    if (!SC_STATEMACHINE_RESET_InLow) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      step_q  <= '0;
      start_q <= 1'b1;
      out_q   <= decode(S_IDLE);
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      start_q <= start_d;
      out_q   <= out_d;
    end
  end

  assign SC_STATEMACHINE_clear_OutLow       = out_q.clear_n;
  assign SC_STATEMACHINE_load_OutLow        = out_q.load_n;
  assign SC_STATEMACHINE_shiftselection_Out = out_q.sel;
  assign SC_STATEMACHINE_busy_Out           = out_q.busy;
  assign SC_STATEMACHINE_done_Out           = out_q.done;

endmodule

// File: tb/tb_sc_statemachine_shifter.sv
// Bench for sc_statemachine_shifter: stimulus queues the expected output
// events (clear, load, shift pulses, done) with their cycle numbers; a monitor
// pops and compares whenever the FSM presents one. A small shift-register
// model follows the outputs to confirm the 8'h01 -> 8'h80 -> 8'h01 sweep.
module tb_sc_statemachine_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_n = 1'b1;
  logic       stop_n = 1'b1;
  logic       rep = 1'b0;
  logic       clr_n, load_n, busy, done;
  logic [1:0] sel;

  sc_statemachine_shifter dut (
    .SC_STATEMACHINE_CLOCK_50          (clk),
    .SC_STATEMACHINE_RESET_InLow       (rst_n),
    .SC_STATEMACHINE_start_InLow       (start_n),
    .SC_STATEMACHINE_stop_InLow        (stop_n),
    .SC_STATEMACHINE_repeat_In         (rep),
    .SC_STATEMACHINE_clear_OutLow      (clr_n),
    .SC_STATEMACHINE_load_OutLow       (load_n),
    .SC_STATEMACHINE_shiftselection_Out(sel),
    .SC_STATEMACHINE_busy_Out          (busy),
    .SC_STATEMACHINE_done_Out          (done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_CLR = 0, K_LOAD = 1, K_SHL = 2, K_SHR = 3, K_DONE = 4, K_BAD = 5;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sr = 8'h00;
  int         last_kind = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // CLR at p, LOAD at p+1; each round is 70 cycles of 7 left + 7 right shifts.
  task automatic push_sweep(input int p, input int rounds, input bit with_done);
    push_ev(K_CLR, p);
    push_ev(K_LOAD, p + 1);
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < 7; i++) push_ev(K_SHL, p + 6 + 70 * r + 5 * i);
      for (int i = 0; i < 7; i++) push_ev(K_SHR, p + 41 + 70 * r + 5 * i);
    end
    if (with_done) push_ev(K_DONE, p + 72 + 70 * (rounds - 1));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One-cycle start press; p is the cycle at which CLR must be visible.
  task automatic press(output int p);
    @(negedge clk);
    start_n = 1'b0;
    p = cyc + 1;
    @(negedge clk);
    start_n = 1'b1;
  endtask

  // Monitor: classify the presented output, compare against the queue head.
  always @(negedge clk) begin : mon
    int   k;
    ev_t  e;
    k = -1;
    if (!clr_n)             k = K_CLR;
    else if (!load_n)       k = K_LOAD;
    else if (sel == 2'b01)  k = K_SHL;
    else if (sel == 2'b10)  k = K_SHR;
    else if (sel == 2'b11)  k = K_BAD;
    else if (done)          k = K_DONE;
    if (k >= 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.at != cyc) begin
          errors++;
          $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   k, cyc, e.kind, e.at);
        end
      end
      chk("busy_during_event", {31'd0, busy}, 32'd1);
      if (k == K_SHR && last_kind == K_SHL) chk("sr_after_left", {24'd0, sr}, 32'h80);
      if (k == K_DONE) chk("sr_at_done", {24'd0, sr}, 32'h01);
      case (k)
        K_CLR:   sr = 8'h00;
        K_LOAD:  sr = 8'h01;
        K_SHL:   sr = sr << 1;
        K_SHR:   sr = sr >> 1;
        default: ;
      endcase
      last_kind = k;
    end
  end

  initial begin
    int p;
    // Reset held with start low, released only after start goes high.
    rst_n   = 1'b0;
    start_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, clr_n, load_n, sel, busy, done}, 32'b110000);
    start_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {31'd0, busy}, 32'd0);

    // Single sweep, repeat off.
    press(p);
    push_sweep(p, 1, 1'b1);
    wait_until(p + 36);
    chk("busy_mid_sweep", {31'd0, busy}, 32'd1);
    wait_until(p + 73);
    chk("idle_after_sweep", {26'd0, clr_n, load_n, sel, busy, done}, 32'b110000);

    // Start bounce during the first SHL.
    press(p);
    push_sweep(p, 1, 1'b1);
    wait_until(p + 6);
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    wait_until(p + 73);
    chk("idle_after_bounce", {31'd0, busy}, 32'd0);

    // Start held low for 100 cycles: exactly one sweep.
    @(negedge clk);
    start_n = 1'b0;
    p = cyc + 1;
    push_sweep(p, 1, 1'b1);
    repeat (100) @(negedge clk);
    start_n = 1'b1;
    wait_until(p + 110);
    chk("idle_after_hold", {31'd0, busy}, 32'd0);

    // Stop mid-WAITR, then a fresh sweep from the start.
    press(p);
    push_ev(K_CLR, p);
    push_ev(K_LOAD, p + 1);
    for (int i = 0; i < 7; i++) push_ev(K_SHL, p + 6 + 5 * i);
    push_ev(K_SHR, p + 41);
    wait_until(p + 44);
    stop_n = 1'b0;
    @(negedge clk);
    stop_n = 1'b1;
    chk("idle_after_stop", {26'd0, clr_n, load_n, sel, busy, done}, 32'b110000);
    press(p);
    push_sweep(p, 1, 1'b1);
    wait_until(p + 73);
    chk("idle_after_restart", {31'd0, busy}, 32'd0);

    // Repeat for three rounds; repeat dropped before the third round ends.
    rep = 1'b1;
    press(p);
    push_sweep(p, 3, 1'b1);
    wait_until(p + 190);
    rep = 1'b0;
    wait_until(p + 205);
    chk("busy_repeat_200", {31'd0, busy}, 32'd1);
    wait_until(p + 213);
    chk("idle_after_repeat", {26'd0, clr_n, load_n, sel, busy, done}, 32'b110000);

    // Start and stop together in IDLE, then stop released with start held low.
    @(negedge clk);
    start_n = 1'b0;
    stop_n  = 1'b0;
    @(negedge clk);
    chk("idle_start_with_stop", {31'd0, busy}, 32'd0);
    stop_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_new_edge", {31'd0, busy}, 32'd0);
    start_n = 1'b1;
    @(negedge clk);

    // Reset mid-sweep during WAITL.
    press(p);
    push_ev(K_CLR, p);
    push_ev(K_LOAD, p + 1);
    for (int i = 0; i < 3; i++) push_ev(K_SHL, p + 6 + 5 * i);
    wait_until(p + 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_sweep", {26'd0, clr_n, load_n, sel, busy, done}, 32'b110000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during DONE: one done pulse only.
    press(p);
    push_sweep(p, 1, 1'b1);
    wait_until(p + 72);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_in_done", {26'd0, clr_n, load_n, sel, busy, done}, 32'b110000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
